// File: rtl/axis_ingress_fifo.sv
// axis_ingress_fifo
// DEPTH-entry AXI-Stream ingress FIFO between the external AXIS port and the
// header parser. The default build is a plain cut-through FIFO. Defining
// AXIS_INGRESS_DROP_EN switches it to store-and-forward operation. In that mode,
// a frame that cannot fit is dropped as a whole, so the parser never sees a
// truncated frame.
module axis_ingress_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int USER_WIDTH = 1,
   parameter int DEPTH      = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   input  logic                  s_tlast,
   input  logic [USER_WIDTH-1:0] s_tuser,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  m_tlast,
   output logic [USER_WIDTH-1:0] m_tuser,
   output logic [CNT_WIDTH-1:0]  drop_count,
   output logic                  drop_pulse
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int WW = DATA_WIDTH + USER_WIDTH + 1;
   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
   localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WW-1:0] mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [PW-1:0] visible_ptr_s;
   logic          full_s;
   logic          wr_en_s;
   logic          rd_en_s;
   logic [WW-1:0] rd_word_s;

   // Pointers carry one extra bit, so a full FIFO and an empty FIFO are distinguishable.
   assign full_s    = ((wr_ptr_r - rd_ptr_r) == DEPTH_P);
   assign m_tvalid  = (rd_ptr_r != visible_ptr_s);
   assign rd_en_s   = m_tvalid && m_tready;
   assign rd_word_s = mem_r[rd_ptr_r[AW-1:0]];
   assign {m_tuser, m_tlast, m_tdata} = rd_word_s;

   // Storage array: one word per beat, packed as {tuser, tlast, tdata}.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= {s_tuser, s_tlast, s_tdata};
      end
   end

   // Read pointer advances on each beat handed to the parser.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_r <= '0;
      end else if (rd_en_s) begin
         rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
   end

`ifdef AXIS_INGRESS_DROP_EN

   typedef enum logic [0:0] {
      ST_ACCEPT = 1'b0,
      ST_DROP   = 1'b1
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                 state_r;
   state_t                 state_nxt_s;
   logic [PW-1:0]          commit_ptr_r;
   logic                   beat_s;
   logic                   commit_s;
   logic                   drop_s;
   logic [CNT_WIDTH-1:0]   drop_count_r;
   logic                   drop_pulse_r;

   // The external port never stalls. Frames that do not fit are discarded instead.
   assign s_tready      = !rst;
   assign beat_s        = s_tvalid && s_tready;
   assign visible_ptr_s = commit_ptr_r;
   assign drop_count    = drop_count_r;
   assign drop_pulse    = drop_pulse_r;

   // Frame accept/drop decision: write, commit on tlast, or drop the partial frame.
   always_comb begin
      state_nxt_s = state_r;
      wr_en_s     = 1'b0;
      commit_s    = 1'b0;
      drop_s      = 1'b0;
      case (state_r)
         ST_ACCEPT: begin
            if (beat_s) begin
               if (!full_s) begin
                  wr_en_s  = 1'b1;
                  commit_s = s_tlast;
               end else begin
                  drop_s = 1'b1;
                  if (s_tlast) begin
                     state_nxt_s = ST_ACCEPT;
                  end else begin
                     state_nxt_s = ST_DROP;
                  end
               end
            end else begin
               state_nxt_s = ST_ACCEPT;
            end
         end
         ST_DROP: begin
            if (beat_s && s_tlast) begin
               state_nxt_s = ST_ACCEPT;
            end else begin
               state_nxt_s = ST_DROP;
            end
         end
         default: begin
            state_nxt_s = ST_ACCEPT;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_ACCEPT;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Write pointer: a drop rewinds it to the last commit point, discarding the partial frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= '0;
      end else if (drop_s) begin
         wr_ptr_r <= commit_ptr_r;
      end else if (wr_en_s) begin
         wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
   end

   // Commit pointer: the whole frame becomes visible when its tlast beat is written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         commit_ptr_r <= '0;
      end else if (commit_s) begin
         commit_ptr_r <= wr_ptr_r + PTR_ONE;
      end
   end

   // Drop statistics: a saturating frame counter and a one-cycle pulse per drop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_count_r <= '0;
         drop_pulse_r <= 1'b0;
      end else begin
         drop_pulse_r <= drop_s;
         if (drop_s && (drop_count_r != CNT_MAX)) begin
            drop_count_r <= drop_count_r + CNT_ONE;
         end
      end
   end

`else

   // Plain FIFO: backpressure when full. Every written beat is visible at once.
   assign s_tready      = !full_s && !rst;
   assign wr_en_s       = s_tvalid && s_tready;
   assign visible_ptr_s = wr_ptr_r;
   assign drop_count    = {CNT_WIDTH{1'b0}};
   assign drop_pulse    = 1'b0;

   // Write pointer advances on every accepted beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= '0;
      end else if (wr_en_s) begin
         wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
   end

`endif

endmodule
